nes_line_buffer: RTL and testbench

NES_LINE_BUFFER -- requirements
Module: nes_line_buffer

---
 rtl/nes_line_buffer.sv | 129 ++++++++++++
 tb/tb_nes_line_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nes_line_buffer.sv
// Two-bank scanline buffer between the NES PPU pixel stream and the display.
// The writer fills one bank while the reader drains the other; each bank
// carries an EMPTY/FILLING/FULL state and the NES line number it holds.
`timescale 1ns/1ps
module nes_line_buffer #(
    parameter int LINE_W = 256,
    parameter int LINE_H = 240
) (
    input  logic       pix_clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [8:0] wr_rgb,
    input  logic       wr_sof,
    input  logic [7:0] rd_ptr_x,
    input  logic [7:0] rd_ptr_y,
    input  logic       reading,
    output logic [8:0] rd_rgb,
    output logic       underrun
);

    typedef enum logic [1:0] {
        B_EMPTY   = 2'd0,
        B_FILLING = 2'd1,
        B_FULL    = 2'd2
    } bank_st_t;

    localparam logic [7:0] X_LAST = 8'(LINE_W - 1);
    localparam logic [7:0] Y_LAST = 8'(LINE_H - 1);

    logic [8:0] ram [2][LINE_W];

    bank_st_t   st_q  [2];
    bank_st_t   st_d  [2];
    logic [7:0] tag_q [2];
    logic [7:0] tag_d [2];
    logic       wb_q, wb_d;
    logic       rb_q, rb_d;
    logic [7:0] wx_q, wx_d;
    logic [7:0] wl_q, wl_d;
    logic       underrun_q, underrun_d;

    logic       wr_acc;
    logic       rd_hit;
    logic       rel;
    logic [7:0] wr_idx;

    // A bank is writable until it is FULL; this alone keeps the writer at
    // most two lines ahead of the reader.
    assign wr_ready = (st_q[wb_q] != B_FULL);
    assign wr_acc   = wr_valid & wr_ready;
    // Start of frame always restarts the current bank at column 0.
    assign wr_idx   = wr_sof ? 8'd0 : wx_q;

    // Display sees data only when the read bank holds exactly the line asked for.
    assign rd_hit   = (st_q[rb_q] == B_FULL) && (tag_q[rb_q] == rd_ptr_y);
    assign rd_rgb   = rd_hit ? ram[rb_q][rd_ptr_x] : 9'h000;
    assign underrun = underrun_q;

    // Release at end of line drops stale lines (tag behind) but holds a line
    // that is still ahead of the display.
    assign rel = reading && (rd_ptr_x == X_LAST) && (st_q[rb_q] == B_FULL) &&
                 (tag_q[rb_q] <= rd_ptr_y);

    // Pixel storage; contents need no reset since bank state gates every read.
    always_ff @(posedge pix_clk) begin
        if (wr_acc) ram[wb_q][wr_idx] <= wr_rgb;
    end

    // Next-state: write-side update first, then read-side release, so both
    // take effect when they land in the same cycle.
    always_comb begin
        st_d       = st_q;
        tag_d      = tag_q;
        wb_d       = wb_q;
        rb_d       = rb_q;
        wx_d       = wx_q;
        wl_d       = wl_q;
        underrun_d = underrun_q;

        if (wr_acc) begin
            if (wr_sof) begin
                st_d[wb_q] = B_FILLING;
                wx_d       = 8'd1;
                wl_d       = 8'd0;
            end else if (wx_q == X_LAST) begin
                st_d[wb_q]  = B_FULL;
                tag_d[wb_q] = wl_q;
                wx_d        = 8'd0;
                wb_d        = ~wb_q;
                wl_d        = (wl_q == Y_LAST) ? 8'd0 : wl_q + 8'd1;
            end else begin
                st_d[wb_q] = B_FILLING;
                wx_d       = wx_q + 8'd1;
            end
        end

        if (rel) begin
            st_d[rb_q] = B_EMPTY;
            rb_d       = ~rb_q;
        end

        if (reading && !rd_hit) underrun_d = 1'b1;
    end

    // Control state; reset abandons every buffered line immediately.
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q[0]    <= B_EMPTY;
            st_q[1]    <= B_EMPTY;
            tag_q[0]   <= 8'd0;
            tag_q[1]   <= 8'd0;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            wx_q       <= 8'd0;
            wl_q       <= 8'd0;
            underrun_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            tag_q      <= tag_d;
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            wx_q       <= wx_d;
            wl_q       <= wl_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_nes_line_buffer.sv
// Directed bench for nes_line_buffer: fill, read/release, underrun,
// stale/ahead lines, simultaneous release+completion, reset mid-line.
`timescale 1ns/1ps
module tb_nes_line_buffer;

    logic       pix_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [8:0] wr_rgb = '0;
    logic       wr_sof = 1'b0;
    logic [7:0] rd_ptr_x = '0;
    logic [7:0] rd_ptr_y = '0;
    logic       reading = 1'b0;
    logic [8:0] rd_rgb;
    logic       underrun;

    int checks = 0;
    int failures = 0;

    nes_line_buffer dut (
        .pix_clk (pix_clk),
        .rst_n   (rst_n),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_rgb  (wr_rgb),
        .wr_sof  (wr_sof),
        .rd_ptr_x(rd_ptr_x),
        .rd_ptr_y(rd_ptr_y),
        .reading (reading),
        .rd_rgb  (rd_rgb),
        .underrun(underrun)
    );

    always #5 pix_clk = ~pix_clk;

    task automatic tick();
        @(posedge pix_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic write_pix(input bit sof, input logic [8:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_sof   = sof && (i == 0);
            wr_rgb   = base + 9'(i);
            tick();
        end
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
    endtask

    task automatic release_line(input logic [7:0] y);
        reading  = 1'b1;
        rd_ptr_x = 8'd255;
        rd_ptr_y = y;
        tick();
        reading  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
        checks++; if (rd_rgb !== 9'h000) begin failures++; $display("FAIL reset_rd_rgb got %h want 000", rd_rgb); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got %b want 0", underrun); end
        checks++; if (dut.wb_q !== 1'b0 || dut.rb_q !== 1'b0) begin failures++; $display("FAIL reset_ptrs got wb=%b rb=%b want 0 0", dut.wb_q, dut.rb_q); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        write_pix(1'b1, 9'h000, 256);
        checks++; if (dut.st_q[0] !== 2'd2 || dut.tag_q[0] !== 8'd0) begin failures++; $display("FAIL fill_bank0 got st=%0d tag=%0d want 2 0", dut.st_q[0], dut.tag_q[0]); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL fill_ready1 got %b want 1", wr_ready); end
        write_pix(1'b0, 9'h100, 256);
        checks++; if (dut.st_q[1] !== 2'd2 || dut.tag_q[1] !== 8'd1) begin failures++; $display("FAIL fill_bank1 got st=%0d tag=%0d want 2 1", dut.st_q[1], dut.tag_q[1]); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL fill_ready0 got %b want 0", wr_ready); end
        // offered pixel while stalled must not be taken
        wr_valid = 1'b1;
        wr_rgb   = 9'h1ff;
        tick();
        wr_valid = 1'b0;
        checks++; if (dut.wx_q !== 8'd0 || dut.wb_q !== 1'b0 || dut.st_q[0] !== 2'd2) begin failures++; $display("FAIL fill_stall got wx=%0d wb=%b st0=%0d want 0 0 2", dut.wx_q, dut.wb_q, dut.st_q[0]); end
    endtask

    task automatic test_read_release();
        int bad = 0;
        reading  = 1'b1;
        rd_ptr_y = 8'd0;
        for (int x = 0; x < 256; x++) begin
            rd_ptr_x = 8'(x);
            #1;
            checks++;
            if (rd_rgb !== 9'(x)) begin
                failures++;
                if (bad < 4) $display("FAIL read_x%0d got %h want %h", x, rd_rgb, 9'(x));
                bad++;
            end
            tick();
        end
        reading = 1'b0;
        checks++; if (dut.st_q[0] !== 2'd0 || dut.rb_q !== 1'b1) begin failures++; $display("FAIL release_bank0 got st=%0d rb=%b want 0 1", dut.st_q[0], dut.rb_q); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL release_ready got %b want 1", wr_ready); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL release_underrun got %b want 0", underrun); end
        rd_ptr_y = 8'd1;
        rd_ptr_x = 8'd5;
        #1;
        checks++; if (rd_rgb !== 9'h105) begin failures++; $display("FAIL read_line1 got %h want 105", rd_rgb); end
    endtask

    task automatic test_underrun();
        do_reset();
        reading  = 1'b1;
        rd_ptr_y = 8'd0;
        rd_ptr_x = 8'd0;
        #1;
        checks++; if (rd_rgb !== 9'h000) begin failures++; $display("FAIL underrun_rgb got %h want 000", rd_rgb); end
        tick();
        reading = 1'b0;
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_set got %b want 1", underrun); end
        write_pix(1'b1, 9'h000, 256);
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_sticky got %b want 1", underrun); end
        rd_ptr_x = 8'd7;
        #1;
        checks++; if (rd_rgb !== 9'h007) begin failures++; $display("FAIL underrun_data got %h want 007", rd_rgb); end
    endtask

    task automatic test_stale_ahead();
        do_reset();
        write_pix(1'b1, 9'h000, 256);  // line 0 -> bank0
        write_pix(1'b0, 9'h020, 256);  // line 1 -> bank1
        release_line(8'd0);
        write_pix(1'b0, 9'h040, 256);  // line 2 -> bank0
        release_line(8'd1);            // rb back to bank0 (tag 2)
        // tag 2 behind display line 3: dropped at x=255
        reading  = 1'b1;
        rd_ptr_y = 8'd3;
        rd_ptr_x = 8'd255;
        tick();
        reading  = 1'b0;
        checks++; if (dut.st_q[0] !== 2'd0 || dut.rb_q !== 1'b1) begin failures++; $display("FAIL stale_release got st0=%0d rb=%b want 0 1", dut.st_q[0], dut.rb_q); end
        write_pix(1'b0, 9'h060, 256);  // line 3 -> bank1
        write_pix(1'b0, 9'h080, 256);  // line 4 -> bank0
        release_line(8'd3);
        write_pix(1'b0, 9'h0a0, 256);  // line 5 -> bank1
        release_line(8'd4);            // rb = bank1, tag 5
        write_pix(1'b0, 9'h0c0, 256);  // line 6 -> bank0
        reading  = 1'b1;
        rd_ptr_y = 8'd3;
        rd_ptr_x = 8'd10;
        #1;
        checks++; if (rd_rgb !== 9'h000) begin failures++; $display("FAIL ahead_rgb got %h want 000", rd_rgb); end
        rd_ptr_x = 8'd255;
        tick();
        reading = 1'b0;
        checks++; if (dut.st_q[1] !== 2'd2 || dut.rb_q !== 1'b1 || dut.tag_q[1] !== 8'd5) begin failures++; $display("FAIL ahead_hold got st1=%0d rb=%b tag=%0d want 2 1 5", dut.st_q[1], dut.rb_q, dut.tag_q[1]); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        write_pix(1'b1, 9'h000, 256);
        write_pix(1'b0, 9'h080, 255);
        wr_valid = 1'b1;
        wr_rgb   = 9'h17f;
        reading  = 1'b1;
        rd_ptr_y = 8'd0;
        rd_ptr_x = 8'd255;
        tick();
        wr_valid = 1'b0;
        reading  = 1'b0;
        checks++; if (dut.st_q[0] !== 2'd0 || dut.st_q[1] !== 2'd2) begin failures++; $display("FAIL simul_states got st0=%0d st1=%0d want 0 2", dut.st_q[0], dut.st_q[1]); end
        checks++; if (dut.wb_q !== 1'b0 || dut.rb_q !== 1'b1 || dut.tag_q[1] !== 8'd1) begin failures++; $display("FAIL simul_ptrs got wb=%b rb=%b tag1=%0d want 0 1 1", dut.wb_q, dut.rb_q, dut.tag_q[1]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_pix(1'b1, 9'h000, 256);
        write_pix(1'b0, 9'h100, 100);
        rd_ptr_y = 8'd0;
        rd_ptr_x = 8'd5;
        #1;
        checks++; if (rd_rgb !== 9'h005) begin failures++; $display("FAIL mid_pre got %h want 005", rd_rgb); end
        rst_n = 1'b0;
        #1;
        checks++; if (wr_ready !== 1'b1 || rd_rgb !== 9'h000) begin failures++; $display("FAIL mid_async got ready=%b rgb=%h want 1 000", wr_ready, rd_rgb); end
        checks++; if (dut.wb_q !== 1'b0 || dut.wx_q !== 8'd0) begin failures++; $display("FAIL mid_ptrs got wb=%b wx=%0d want 0 0", dut.wb_q, dut.wx_q); end
        #2;
        rst_n = 1'b1;
        tick();
        write_pix(1'b0, 9'h040, 256);
        checks++; if (dut.st_q[0] !== 2'd2 || dut.tag_q[0] !== 8'd0) begin failures++; $display("FAIL mid_line got st0=%0d tag0=%0d want 2 0", dut.st_q[0], dut.tag_q[0]); end
        rd_ptr_x = 8'd3;
        #1;
        checks++; if (rd_rgb !== 9'h043) begin failures++; $display("FAIL mid_data got %h want 043", rd_rgb); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_read_release();
        test_underrun();
        test_stale_ahead();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
